axioma_lsu: RTL and testbench

Load/store unit between the CPU execute stage and the data-memory SRAM controller. It turns one decoded LD/ST/LDD/STD-style request into effective-address computation, pointer update and one or two byte-wide memory transactions. It returns the load result, the updated pointer and an error flag to the register-file writeback.

---
 rtl/axioma_lsu_if.sv | 42 ++++
 rtl/axioma_lsu.sv | 234 +++++++++++++++++++++++
 tb/tb_axioma_lsu.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axioma_lsu_if.sv
// Request, response and SRAM-side signal bundle of the load/store unit.
interface axioma_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_mode;
  logic [15:0] req_ptr;
  logic [5:0]  req_disp;
  logic [15:0] req_wdata;
  logic [4:0]  req_tag;

  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic [15:0] resp_ptr;
  logic        resp_ptr_we;
  logic [4:0]  resp_tag;
  logic        resp_err;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_rdata;

  logic        busy;

  // Environment side: execute stage issuing requests plus the SRAM controller.
  modport master (
    output req_valid, req_op, req_mode, req_ptr, req_disp, req_wdata, req_tag,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_ptr, resp_ptr_we, resp_tag, resp_err,
    input  mem_addr, mem_wdata, mem_read, mem_write, busy
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_op, req_mode, req_ptr, req_disp, req_wdata, req_tag,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_ptr, resp_ptr_we, resp_tag, resp_err,
    output mem_addr, mem_wdata, mem_read, mem_write, busy
  );
endinterface

// File: rtl/axioma_lsu.sv
// Load/store unit: EA/pointer update, bounds check, one or two byte-wide SRAM
// accesses (little-endian, low byte first) and a registered writeback response.
module axioma_lsu #(
  parameter int unsigned MEM_LAT = 2,
  parameter logic [15:0] ADDR_LO = 16'h0020,
  parameter logic [15:0] ADDR_HI = 16'h08FF
) (
  input  logic         clk,
  input  logic         reset_n,
  axioma_lsu_if.slave  bus
);

  localparam int unsigned CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_e;

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [4:0]    tag_q, tag_d;
  logic [15:0]   nptr_q, nptr_d;
  logic          pwe_q, pwe_d;
  logic          hi_q, hi_d;
  logic [15:0]   rdata_q, rdata_d;

  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          req_ready_q, req_ready_d;
  logic          busy_q, busy_d;
  logic          resp_valid_q, resp_valid_d;
  logic [15:0]   resp_rdata_q, resp_rdata_d;
  logic [15:0]   resp_ptr_q, resp_ptr_d;
  logic          resp_ptr_we_q, resp_ptr_we_d;
  logic [4:0]    resp_tag_q, resp_tag_d;
  logic          resp_err_q, resp_err_d;

  logic [16:0]   size17_c, ea17_c, inc17_c, last17_c;
  logic [15:0]   nptr_c;
  logic          wrap_c, err_c;
  logic          wait_done_c;

  // Effective address, updated pointer and legality of the incoming request.
  always_comb begin
    size17_c = bus.req_op[1] ? 17'd2 : 17'd1;
    ea17_c   = {1'b0, bus.req_ptr};
    inc17_c  = {1'b0, bus.req_ptr} + size17_c;
    nptr_c   = bus.req_ptr;
    wrap_c   = 1'b0;
    unique case (bus.req_mode)
      2'b01: begin
        nptr_c = inc17_c[15:0];
        wrap_c = inc17_c[16];
      end
      2'b10: begin
        ea17_c = {1'b0, bus.req_ptr} - size17_c;
        nptr_c = ea17_c[15:0];
        wrap_c = ea17_c[16];
      end
      2'b11: begin
        ea17_c = {1'b0, bus.req_ptr} + {11'd0, bus.req_disp};
        wrap_c = ea17_c[16];
      end
      default: ;
    endcase
    last17_c = {1'b0, ea17_c[15:0]} + size17_c - 17'd1;
    err_c    = wrap_c | last17_c[16] | (ea17_c[15:0] < ADDR_LO) |
               (last17_c[15:0] > ADDR_HI);
  end

  assign wait_done_c = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = err_c ? S_ERR : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_done_c) state_d = (op_q[1] && !hi_q) ? S_ISSUE : S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values; strobes are set on entry to ISSUE.
  always_comb begin
    cnt_d         = cnt_q;
    op_d          = op_q;
    wdata_d       = wdata_q;
    tag_d         = tag_q;
    nptr_d        = nptr_q;
    pwe_d         = pwe_q;
    hi_d          = hi_q;
    rdata_d       = rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_ptr_d    = resp_ptr_q;
    resp_ptr_we_d = resp_ptr_we_q;
    resp_tag_d    = resp_tag_q;
    resp_err_d    = resp_err_q;
    req_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          wdata_d = bus.req_wdata;
          tag_d   = bus.req_tag;
          nptr_d  = nptr_c;
          pwe_d   = (bus.req_mode == 2'b01) || (bus.req_mode == 2'b10);
          hi_d    = 1'b0;
          rdata_d = 16'h0000;
          cnt_d   = '0;
          if (err_c) begin
            resp_valid_d  = 1'b1;
            resp_err_d    = 1'b1;
            resp_rdata_d  = 16'h0000;
            resp_ptr_d    = bus.req_ptr;
            resp_ptr_we_d = 1'b0;
            resp_tag_d    = bus.req_tag;
          end else begin
            mem_addr_d  = ea17_c[15:0];
            mem_wdata_d = bus.req_wdata[7:0];
            mem_read_d  = ~bus.req_op[0];
            mem_write_d = bus.req_op[0];
          end
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        if (wait_done_c) begin
          if (!op_q[0]) begin
            if (hi_q) rdata_d[15:8] = bus.mem_rdata;
            else      rdata_d[7:0]  = bus.mem_rdata;
          end
          if (op_q[1] && !hi_q) begin
            hi_d        = 1'b1;
            mem_addr_d  = mem_addr_q + 16'd1;
            mem_wdata_d = wdata_q[15:8];
            mem_read_d  = ~op_q[0];
            mem_write_d = op_q[0];
          end else begin
            resp_valid_d  = 1'b1;
            resp_err_d    = 1'b0;
            resp_rdata_d  = op_q[0] ? 16'h0000 : rdata_d;
            resp_ptr_d    = nptr_q;
            resp_ptr_we_d = pwe_q;
            resp_tag_d    = tag_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      op_q          <= 2'b00;
      wdata_q       <= 16'h0000;
      tag_q         <= 5'd0;
      nptr_q        <= 16'h0000;
      pwe_q         <= 1'b0;
      hi_q          <= 1'b0;
      rdata_q       <= 16'h0000;
      mem_addr_q    <= 16'h0000;
      mem_wdata_q   <= 8'h00;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 16'h0000;
      resp_ptr_q    <= 16'h0000;
      resp_ptr_we_q <= 1'b0;
      resp_tag_q    <= 5'd0;
      resp_err_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      wdata_q       <= wdata_d;
      tag_q         <= tag_d;
      nptr_q        <= nptr_d;
      pwe_q         <= pwe_d;
      hi_q          <= hi_d;
      rdata_q       <= rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_ptr_q    <= resp_ptr_d;
      resp_ptr_we_q <= resp_ptr_we_d;
      resp_tag_q    <= resp_tag_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.busy        = busy_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_ptr    = resp_ptr_q;
  assign bus.resp_ptr_we = resp_ptr_we_q;
  assign bus.resp_tag    = resp_tag_q;
  assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_axioma_lsu.sv
// Directed scoreboard bench for axioma_lsu: requests push expected strobes and
// responses; a negedge monitor pops and compares them as the unit produces them.
module tb_axioma_lsu;
  localparam int unsigned L = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  axioma_lsu_if bus();

  axioma_lsu #(.MEM_LAT(L), .ADDR_LO(16'h0020), .ADDR_HI(16'h08FF)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } strobe_t;

  typedef struct {
    logic [15:0] rdata;
    logic [15:0] ptr;
    logic        we;
    logic        err;
    logic [4:0]  tag;
    int          cyc;
  } resp_t;

  strobe_t sq[$];
  resp_t   rq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SRAM model: data valid only in the last latency cycle after a read strobe.
  logic [7:0]  mem [0:4095];
  bit          rd_pend = 1'b0;
  int          rd_cnt = 0;
  logic [15:0] rd_addr = 16'h0000;

  always @(negedge clk) begin
    if (!reset_n) begin
      rd_pend = 1'b0;
      bus.mem_rdata = 8'hEE;
      mem[12'h100] = 8'hA5;
      mem[12'h2FE] = 8'hCD;
      mem[12'h2FF] = 8'hAB;
      mem[12'h8FE] = 8'h11;
      mem[12'h8FF] = 8'h3C;
      mem[12'h400] = 8'h81;
      mem[12'h501] = 8'h00;
    end else begin
      if (rd_pend) rd_cnt++;
      if (bus.mem_read) begin
        rd_pend = 1'b1;
        rd_cnt  = 0;
        rd_addr = bus.mem_addr;
      end
      if (bus.mem_write) mem[bus.mem_addr[11:0]] = bus.mem_wdata;
      if (rd_pend && rd_cnt == int'(L)) begin
        bus.mem_rdata = mem[rd_addr[11:0]];
        rd_pend = 1'b0;
      end else begin
        bus.mem_rdata = 8'hEE;
      end
    end
  end

  // Monitor: compare every strobe and response against the queued expectations.
  always @(negedge clk) begin
    strobe_t s;
    resp_t   r;
    if (reset_n) begin
      if (bus.mem_read && bus.mem_write) chk("strobe_exclusive", 32'd1, 32'd0);
      if (bus.mem_read || bus.mem_write) begin
        if (sq.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
        else begin
          s = sq.pop_front();
          chk("strobe_wr", 32'(bus.mem_write), 32'(s.wr));
          chk("strobe_addr", 32'(bus.mem_addr), 32'(s.addr));
          if (s.wr) chk("strobe_wdata", 32'(bus.mem_wdata), 32'(s.data));
          chk("strobe_cycle", 32'(cyc), 32'(s.cyc));
        end
      end
      if (bus.resp_valid) begin
        if (rq.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          r = rq.pop_front();
          chk("resp_rdata", 32'(bus.resp_rdata), 32'(r.rdata));
          chk("resp_ptr", 32'(bus.resp_ptr), 32'(r.ptr));
          chk("resp_ptr_we", 32'(bus.resp_ptr_we), 32'(r.we));
          chk("resp_err", 32'(bus.resp_err), 32'(r.err));
          chk("resp_tag", 32'(bus.resp_tag), 32'(r.tag));
          chk("resp_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
    end
  end

  // Issue one request (called at a negedge); expectations are hand-supplied.
  task automatic do_req(input logic [1:0] op, input logic [1:0] mode,
                        input logic [15:0] ptr, input logic [5:0] disp,
                        input logic [15:0] wdata, input logic [4:0] tag,
                        input logic [15:0] ea, input bit err,
                        input logic [15:0] rdata, input logic [15:0] nptr,
                        input bit want_resp);
    int a;
    a = -1;
    bus.req_op    = op;
    bus.req_mode  = mode;
    bus.req_ptr   = ptr;
    bus.req_disp  = disp;
    bus.req_wdata = wdata;
    bus.req_tag   = tag;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready) begin
        a = cyc;
        break;
      end
      @(negedge clk);
    end
    if (a < 0) begin
      chk("req_accept_timeout", 32'd1, 32'd0);
      bus.req_valid = 1'b0;
      return;
    end
    if (!err) begin
      sq.push_back('{wr: op[0], addr: ea, data: wdata[7:0], cyc: a + 1});
      if (op[1] && want_resp)
        sq.push_back('{wr: op[0], addr: ea + 16'd1, data: wdata[15:8], cyc: a + 2 + int'(L)});
    end
    if (want_resp)
      rq.push_back('{rdata: rdata, ptr: nptr,
                     we: !err && (mode == 2'b01 || mode == 2'b10),
                     err: err, tag: tag,
                     cyc: err ? a + 1 : (op[1] ? a + 3 + 2 * int'(L) : a + 2 + int'(L))});
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rq.size() == 0 && sq.size() == 0 && bus.req_ready) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_mode  = 2'b00;
    bus.req_ptr   = 16'h0000;
    bus.req_disp  = 6'd0;
    bus.req_wdata = 16'h0000;
    bus.req_tag   = 5'd0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
    chk("rst_resp_ptr", 32'(bus.resp_ptr), 32'd0);
    chk("rst_resp_ptr_we", 32'(bus.resp_ptr_we), 32'd0);
    chk("rst_resp_tag", 32'(bus.resp_tag), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    //      op     mode   ptr       disp   wdata     tag    ea        err   rdata     nptr      resp
    do_req(2'b00, 2'b00, 16'h0100, 6'd0,  16'h0000, 5'd3,  16'h0100, 1'b0, 16'h00A5, 16'h0100, 1'b1);
    do_req(2'b11, 2'b01, 16'h0200, 6'd0,  16'h1234, 5'd4,  16'h0200, 1'b0, 16'h0000, 16'h0202, 1'b1);
    do_req(2'b10, 2'b10, 16'h0300, 6'd0,  16'h0000, 5'd5,  16'h02FE, 1'b0, 16'hABCD, 16'h02FE, 1'b1);
    wait_idle();

    // Word at 0x08FF crosses the top bound: error response one cycle after accept.
    do_req(2'b10, 2'b11, 16'h08C0, 6'd63, 16'h0000, 5'd6,  16'h08FF, 1'b1, 16'h0000, 16'h08C0, 1'b1);
    chk("err_ready_low", 32'(bus.req_ready), 32'd0);
    chk("err_busy_high", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("err_ready_back", 32'(bus.req_ready), 32'd1);
    chk("err_busy_low", 32'(bus.busy), 32'd0);

    do_req(2'b00, 2'b11, 16'h08C0, 6'd63, 16'h0000, 5'd7,  16'h08FF, 1'b0, 16'h003C, 16'h08C0, 1'b1);
    do_req(2'b00, 2'b10, 16'h0000, 6'd0,  16'h0000, 5'd8,  16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1'b1);
    do_req(2'b00, 2'b00, 16'h001F, 6'd0,  16'h0000, 5'd9,  16'h001F, 1'b1, 16'h0000, 16'h001F, 1'b1);
    do_req(2'b01, 2'b00, 16'h0020, 6'd0,  16'hFF77, 5'd10, 16'h0020, 1'b0, 16'h0000, 16'h0020, 1'b1);
    do_req(2'b00, 2'b01, 16'h0400, 6'd0,  16'h0000, 5'd11, 16'h0400, 1'b0, 16'h0081, 16'h0401, 1'b1);
    do_req(2'b10, 2'b00, 16'h08FE, 6'd0,  16'h0000, 5'd12, 16'h08FE, 1'b0, 16'h3C11, 16'h08FE, 1'b1);
    wait_idle();
    chk("mem_0020", 32'(mem[12'h020]), 32'h77);
    chk("mem_0200", 32'(mem[12'h200]), 32'h34);
    chk("mem_0201", 32'(mem[12'h201]), 32'h12);

    // Reset while waiting on the first byte of a word store: second byte never written.
    do_req(2'b11, 2'b00, 16'h0500, 6'd0,  16'hBEEF, 5'd13, 16'h0500, 1'b0, 16'h0000, 16'h0500, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("midrst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_mem_0501", 32'(mem[12'h501]), 32'h00);
    chk("midrst_mem_0500", 32'(mem[12'h500]), 32'hEF);
    chk("midrst_ready_after", 32'(bus.req_ready), 32'd1);
    do_req(2'b00, 2'b00, 16'h0500, 6'd0,  16'h0000, 5'd14, 16'h0500, 1'b0, 16'h00EF, 16'h0500, 1'b1);
    wait_idle();

    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("strobe_queue_empty", 32'(sq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
